// File: rtl/mux_sched_pkg.sv
// Shared constants, FSM state type and select-encoding helper for the
// round-robin mux scheduler.
package mux_sched_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_e;

   // Returns {s0, s1}: s1 picks the pair member, s0 picks the pair.
   function automatic logic [1:0] idx_to_sel(input logic [IDX_W-1:0] idx);
      return {idx[1], idx[0]};
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: first set bit of req searching
// start, start+1, ... modulo 4.
module rr_pick4
   import mux_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // Scan from the far end so the candidate closest to start is written last.
   always_comb begin
      found = 1'b0;
      idx   = start;
      cand  = start;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = start + IDX_W'(k);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin owner scheduler driving the s1/s0 selects of a 4:1 mux, with a
// bounded hold burst per owner and registered grant outputs.
module mux4_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic               s1,
   output logic               s0,
   output logic               busy
);

   localparam int unsigned      CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     own_q, own_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [1:0]           sel_q, sel_d;
   logic                 busy_q, busy_d;

   logic [NUM_REQ-1:0]   others;
   logic [IDX_W-1:0]     own_inc;
   logic                 ptr_found, next_found;
   logic [IDX_W-1:0]     ptr_idx, next_idx;
   logic                 take;
   logic [IDX_W-1:0]     take_idx;

   assign others  = req & ~(NUM_REQ'(1) << own_q);
   assign own_inc = own_q + IDX_W'(1);

   rr_pick4 u_pick_ptr (
      .req   (req),
      .start (ptr_q),
      .found (ptr_found),
      .idx   (ptr_idx)
   );

   rr_pick4 u_pick_next (
      .req   (others),
      .start (own_inc),
      .found (next_found),
      .idx   (next_idx)
   );

   always_comb begin
      state_d  = state_q;
      own_d    = own_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      sel_d    = sel_q;
      busy_d   = busy_q;
      take     = 1'b0;
      take_idx = '0;

      case (state_q)
         ST_IDLE: begin
            if (en && ptr_found) begin
               take     = 1'b1;
               take_idx = ptr_idx;
            end
         end
         ST_OWN: begin
            if (!req[own_q]) begin
               if (en && next_found) begin
                  take     = 1'b1;
                  take_idx = next_idx;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end
            end else if (cnt_q == CNT_LAST) begin
               // With en low the counter simply saturates here until released.
               if (en && next_found) begin
                  take     = 1'b1;
                  take_idx = next_idx;
               end else if (en) begin
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (take) begin
         state_d = ST_OWN;
         own_d   = take_idx;
         ptr_d   = take_idx + IDX_W'(1);
         cnt_d   = '0;
         gnt_d   = NUM_REQ'(1) << take_idx;
         sel_d   = idx_to_sel(take_idx);
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         own_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt  = gnt_q;
   assign s1   = sel_q[0];
   assign s0   = sel_q[1];
   assign busy = busy_q;

endmodule
